rv64_alu_regfile: RTL and testbench
===================================

Name: rv64_alu_regfile

Overview:
- Combined datapath block for the single-cycle RV64 core.
- Contains a 64-bit combinational ALU with add and unsigned set-less-than operations.
- Contains a 32x64 general-purpose register file with two asynchronous read ports and one synchronous write port.
- Sits between the decoder/immediate logic and the PC/writeback logic; x0 is hardwired to zero.

Parameters:
- XLEN, 64, data width of ALU operands and registers.
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- alu_src1  input  64  ALU operand 1.
- alu_src2  input  64  ALU operand 2 (immediate).
- aluop  input  2  operation select: bit0 = add, bit1 = sltu.
- alu_result  output  64  ALU result, combinational.
- raddr1  input  5  read port 1 address.
- rdata1  output  64  read port 1 data, combinational.
- raddr2  input  5  read port 2 address.
- rdata2  output  64  read port 2 data, combinational.
- we  input  1  write enable.
- waddr  input  5  write address.
- wdata  input  64  write data.

Behaviour:
- ALU is purely combinational, with zero latency.
- Each aluop bit enables one term; alu_result is the bitwise OR of the enabled terms.
  - aluop[0] term: alu_src1 + alu_src2, modulo 2^64; carry is discarded.
  - aluop[1] term: 64'd1 if alu_src1 < alu_src2 as unsigned values, else 64'd0.
  - aluop = 00: alu_result = 0.
  - aluop = 11: alu_result = sum OR sltu bit. This combination is legal but unused by the decoder.
- Register file storage: registers x1..x31, each 64 bits.
- Reads are asynchronous. rdataN = 0 when raddrN == 0; otherwise rdataN = current content of the addressed register.
- Write: on rising clk with we=1, rst=0 and waddr != 0, the register at waddr takes wdata.
  - A write to x0 is silently dropped.
  - we=0 leaves all registers unchanged.
- Reset: on rising clk with rst=1, registers x1..x31 are cleared to 0.
  - rst has priority over a simultaneous write; the write is lost.
  - Reset asserted mid-operation takes effect at the next edge regardless of we.
- Outputs after reset: rdata1 = rdata2 = 0 for every address. alu_result is unaffected by reset, since it depends only on inputs.
- Read-during-write to the same address in one cycle: without the optional feature, rdata returns the old value and the new value is visible after the edge.
- Both read ports may address the same register simultaneously; both return the same value.
- No X propagation: all outputs are defined for every input combination once reset has been applied.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read port whose address equals waddr while we=1, waddr != 0 and rst=0 returns wdata combinationally in the same cycle (write-to-read forwarding).
- Not defined: no forwarding; reads always return stored contents as specified above.
- x0 reads return 0 in both builds.

Test Plan:
- Reset clears: write x5 = 64'hDEAD_BEEF, assert rst for one edge, then read raddr1=5 -> rdata1 = 0.
- Write/read with x0 protection: we=1, waddr=10, wdata=64'h1234_5678_8765_4321, then edge.
  - raddr2=10 -> 64'h1234_5678_8765_4321.
  - Write waddr=0 with wdata=64'hFFFF..FF -> raddr1=0 still reads 0.
- ALU add with wrap: aluop=01.
  - src1 = 64'hFFFF_FFFF_FFFF_FFFF, src2 = 64'h2 -> result 64'h1.
  - src1 = 64'h8000_0000, src2 = -4 (64'hFFFF_FFFF_FFFF_FFFC) -> 64'h7FFF_FFFC.
- ALU sltu: aluop=10.
  - src1 = 3, src2 = 64'hFFFF_FFFF_FFFF_FFFF -> 1.
  - src1 = 64'hFFFF_FFFF_FFFF_FFFF, src2 = 3 -> 0.
  - src1 = src2 = 7 -> 0.
- aluop=00 with any operands -> result 0.
- Simultaneous events:
  - rst=1 and we=1, waddr=3, wdata=9 in the same cycle -> x3 reads 0 after the edge.
  - With we=1, waddr=4, wdata=64'hAA, raddr1=4 before the edge: rdata1 = old value (0) without RF_BYPASS_EN, 64'hAA with RF_BYPASS_EN.

Source files
------------

// File: rtl/rv64_alu_regfile_if.sv
// ----------------------------------------------------------------------------
// rv64_alu_regfile_if
//   Bundles the ALU and register-file signals of rv64_alu_regfile.
//
//   Parameters:
//     XLEN   data width of ALU operands and registers (default 64)
//     NREG   number of architectural registers (default 32)
//
//   Signals:
//     alu_src1, alu_src2  ALU operands
//     aluop               bit0 enables the sum term, bit1 the sltu term
//     alu_result          ALU result (combinational)
//     raddr1/rdata1       read port 1 (asynchronous)
//     raddr2/rdata2       read port 2 (asynchronous)
//     we, waddr, wdata    synchronous write port
//
//   Modports:
//     master  the side that drives operands/addresses (decoder, testbench)
//     slave   the datapath block itself
// ----------------------------------------------------------------------------
interface rv64_alu_regfile_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [1:0]      aluop;
    logic [XLEN-1:0] alu_result;

    logic [AW-1:0]   raddr1;
    logic [XLEN-1:0] rdata1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata2;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    modport master (
        output alu_src1, alu_src2, aluop,
        output raddr1, raddr2,
        output we, waddr, wdata,
        input  alu_result, rdata1, rdata2
    );

    modport slave (
        input  alu_src1, alu_src2, aluop,
        input  raddr1, raddr2,
        input  we, waddr, wdata,
        output alu_result, rdata1, rdata2
    );
endinterface

// File: rtl/rv64_alu_regfile.sv
// ----------------------------------------------------------------------------
// rv64_alu_regfile
//   Datapath block of the single-cycle RV64 core: a combinational ALU
//   (add, unsigned set-less-than) and a 32 x XLEN register file with two
//   asynchronous read ports and one synchronous write port. x0 reads as zero
//   and ignores writes.
//
//   Ports:
//     clk   system clock, all state updates on the rising edge
//     rst   synchronous active-high reset, clears x1..x31, beats a write
//     bus   rv64_alu_regfile_if.slave (ALU operands/result, read/write ports)
//
//   Build option:
//     RF_BYPASS_EN  when defined, a read port whose address matches an active
//                   write (we=1, waddr!=0, rst=0) returns wdata in the same
//                   cycle. When undefined, reads always return stored data.
// ----------------------------------------------------------------------------
module rv64_alu_regfile #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv64_alu_regfile_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREG);

    // ------------------------------------------------------------------
    // ALU: each aluop bit gates one term, result is the OR of the terms.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] sum_term;
    logic [XLEN-1:0] sltu_term;

    always_comb begin
        sum_term  = bus.alu_src1 + bus.alu_src2;
        sltu_term = '0;
        sltu_term[0] = (bus.alu_src1 < bus.alu_src2);
    end

    always_comb begin
        bus.alu_result = '0;
        if (bus.aluop[0]) bus.alu_result = bus.alu_result | sum_term;
        if (bus.aluop[1]) bus.alu_result = bus.alu_result | sltu_term;
    end

    // ------------------------------------------------------------------
    // Register file: only x1..x(NREG-1) have storage.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [1:NREG-1];

    logic wr_en;
    assign wr_en = bus.we && (bus.waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

`ifdef RF_BYPASS_EN
    // Forward only a write that will actually commit at the next edge.
    logic fwd1;
    logic fwd2;
    assign fwd1 = wr_en && !rst && (bus.raddr1 == bus.waddr);
    assign fwd2 = wr_en && !rst && (bus.raddr2 == bus.waddr);
`endif

    always_comb begin
        bus.rdata1 = '0;
        if (bus.raddr1 != '0) begin
`ifdef RF_BYPASS_EN
            bus.rdata1 = fwd1 ? bus.wdata : regs[bus.raddr1];
`else
            bus.rdata1 = regs[bus.raddr1];
`endif
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (bus.raddr2 != '0) begin
`ifdef RF_BYPASS_EN
            bus.rdata2 = fwd2 ? bus.wdata : regs[bus.raddr2];
`else
            bus.rdata2 = regs[bus.raddr2];
`endif
        end
    end

endmodule

// File: tb/tb_rv64_alu_regfile.sv
// ----------------------------------------------------------------------------
// tb_rv64_alu_regfile
//   Directed self-checking bench for rv64_alu_regfile. Expected values are
//   hand-computed constants. Inputs change 1 time unit after a rising edge;
//   outputs are checked 1 more time unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_rv64_alu_regfile;
    logic clk = 1'b0;
    logic rst;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;
    int unsigned n_failed = 0;

    always #5 clk = ~clk;

    rv64_alu_regfile_if #(.XLEN(64), .NREG(32)) bus ();

    rv64_alu_regfile #(.XLEN(64), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; returns 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.alu_src1 = '0;
        bus.alu_src2 = '0;
        bus.aluop    = 2'b00;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;

        tick();
        tick();

        // ALU is independent of reset
        bus.aluop    = 2'b01;
        bus.alu_src1 = 64'd1;
        bus.alu_src2 = 64'd2;
        settle();
        check("alu_add_in_reset", bus.alu_result, 64'd3);

        // Reset state of both read ports
        rst        = 1'b0;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd31;
        settle();
        check("reset_x5", bus.rdata1, 64'd0);
        check("reset_x31", bus.rdata2, 64'd0);

        // Write x5, then reset clears it
        bus.we    = 1'b1;
        bus.waddr = 5'd5;
        bus.wdata = 64'hDEAD_BEEF;
        tick();
        bus.we = 1'b0;
        settle();
        check("write_x5", bus.rdata1, 64'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("reset_clears_x5", bus.rdata1, 64'd0);

        // Write x10, read on port 2
        bus.we     = 1'b1;
        bus.waddr  = 5'd10;
        bus.wdata  = 64'h1234_5678_8765_4321;
        bus.raddr2 = 5'd10;
        tick();
        settle();
        check("read_x10_p2", bus.rdata2, 64'h1234_5678_8765_4321);

        // Write to x0 is dropped
        bus.waddr  = 5'd0;
        bus.wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.raddr1 = 5'd0;
        settle();
        check("x0_during_write", bus.rdata1, 64'd0);
        tick();
        bus.we = 1'b0;
        settle();
        check("x0_after_write", bus.rdata1, 64'd0);
        check("x10_intact", bus.rdata2, 64'h1234_5678_8765_4321);

        // Both ports on the same register
        bus.raddr1 = 5'd10;
        settle();
        check("dual_port_p1", bus.rdata1, 64'h1234_5678_8765_4321);
        check("dual_port_p2", bus.rdata2, 64'h1234_5678_8765_4321);

        // we=0 leaves registers unchanged
        bus.we    = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 64'h77;
        tick();
        bus.we     = 1'b0;
        bus.wdata  = 64'h5555;
        bus.raddr1 = 5'd7;
        tick();
        check("we0_hold_x7", bus.rdata1, 64'h77);

        // ALU add with wrap
        bus.aluop    = 2'b01;
        bus.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.alu_src2 = 64'h2;
        settle();
        check("add_wrap", bus.alu_result, 64'h1);
        bus.alu_src1 = 64'h8000_0000;
        bus.alu_src2 = 64'hFFFF_FFFF_FFFF_FFFC;
        settle();
        check("add_neg4", bus.alu_result, 64'h7FFF_FFFC);

        // ALU sltu
        bus.aluop    = 2'b10;
        bus.alu_src1 = 64'd3;
        bus.alu_src2 = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        check("sltu_lt", bus.alu_result, 64'd1);
        bus.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.alu_src2 = 64'd3;
        settle();
        check("sltu_gt", bus.alu_result, 64'd0);
        bus.alu_src1 = 64'd7;
        bus.alu_src2 = 64'd7;
        settle();
        check("sltu_eq", bus.alu_result, 64'd0);

        // aluop 00 yields zero
        bus.aluop    = 2'b00;
        bus.alu_src1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.alu_src2 = 64'h1234;
        settle();
        check("aluop_00", bus.alu_result, 64'd0);

        // aluop 11: sum 6 OR sltu 1 = 7
        bus.aluop    = 2'b11;
        bus.alu_src1 = 64'd2;
        bus.alu_src2 = 64'd4;
        settle();
        check("aluop_11", bus.alu_result, 64'd7);

        // Reset beats a simultaneous write
        bus.we     = 1'b1;
        bus.waddr  = 5'd3;
        bus.wdata  = 64'd5;
        bus.raddr1 = 5'd3;
        tick();
        settle();
        check("x3_pre", bus.rdata1, 64'd5);
        rst       = 1'b1;
        bus.wdata = 64'd9;
        tick();
        rst    = 1'b0;
        bus.we = 1'b0;
        settle();
        check("rst_beats_write", bus.rdata1, 64'd0);

        // Read-during-write on x4 (x4 holds 0 after the reset above)
        bus.we     = 1'b1;
        bus.waddr  = 5'd4;
        bus.wdata  = 64'hAA;
        bus.raddr1 = 5'd4;
        bus.raddr2 = 5'd4;
        settle();
`ifdef RF_BYPASS_EN
        check("rdw_p1_before", bus.rdata1, 64'hAA);
        check("rdw_p2_before", bus.rdata2, 64'hAA);
`else
        check("rdw_p1_before", bus.rdata1, 64'd0);
        check("rdw_p2_before", bus.rdata2, 64'd0);
`endif
        // Reset in the same cycle suppresses forwarding too
        rst = 1'b1;
        settle();
        check("rdw_under_rst", bus.rdata1, 64'd0);
        rst = 1'b0;
        tick();
        bus.we = 1'b0;
        settle();
        check("rdw_p1_after", bus.rdata1, 64'hAA);

        // x0 read while writing x0 stays zero in every build
        bus.we     = 1'b1;
        bus.waddr  = 5'd0;
        bus.wdata  = 64'hABCD;
        bus.raddr1 = 5'd0;
        settle();
        check("x0_no_fwd", bus.rdata1, 64'd0);
        bus.we = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
